qspi_xfer_ctrl: RTL and testbench
=================================

Name: qspi_xfer_ctrl

Overview:
- Transaction sequencer for the quad-SPI transmit nibble shifter.
- Accepts one flash command per request: opcode, optional 24-bit address, dummy cycles and N 32-bit write words.
- Issues these to the shifter as back-to-back segments by driving its busy, tsize and din inputs. Ends each segment on the shifter's bit_index feedback.
- Owns chip-select and the completion pulse. Sits between the register/bus front-end and the shifter.

Parameters:
- MSB_FIRST, 1, 1: segment data is nibble-reversed so the most significant nibble goes on the wire first. 0: least significant nibble first.
- CS_GAP_CYC, 2, minimum cycles cs_no stays high between transactions (1..15).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  transaction request
- req_ready_o  out  1  high only in IDLE
- req_opcode_i  in  8  command opcode
- req_addr_en_i  in  1  send address phase
- req_addr_i  in  24  flash address
- req_dummy_i  in  4  dummy nibble cycles (0 = skip)
- req_words_i  in  8  write words (0 = no data phase)
- wr_valid_i  in  1  write word available
- wr_data_i  in  32  write word
- wr_ready_o  out  1  word consumed (1-cycle pulse)
- abort_i  in  1  terminate current transaction
- sh_busy_o  out  1  shifter busy
- sh_tsize_o  out  6  segment size in bits (multiple of 4)
- sh_din_o  out  40  segment data
- sh_bit_index_i  in  6  shifter bit index feedback
- cs_no  out  1  flash chip select, active low
- busy_o  out  1  transaction in progress (state != IDLE)
- done_o  out  1  1-cycle completion pulse
- done_err_o  out  1  qualifies done_o: transaction was aborted

Behaviour:
- Reset values (rst_i high at a clk_i edge): state IDLE, req_ready_o=1, cs_no=1, sh_busy_o=0, sh_tsize_o=0, sh_din_o=0, wr_ready_o=0, done_o=0, done_err_o=0, all counters 0. Reset mid-transaction drops cs_no immediately at that edge, with no gap enforcement.
- All outputs are registered.
- States: IDLE, CMD, ADDR, DUMMY, DWAIT, DATA, GAP.
- IDLE: on req_valid_i, latch all req_* fields. Next edge: cs_no=0, sh_busy_o=1, state CMD with tsize=8, din[7:0]=opcode.
- Segment end: the cycle where sh_busy_o=1 and sh_bit_index_i==sh_tsize_o. At that edge the next segment's tsize/din load and sh_busy_o stays 1, so a segment lasts tsize/4+1 cycles with no bubble.
- Phase order: CMD, then ADDR (tsize=24, addr) if addr_en, then DUMMY (tsize=4*dummy, din=0) if dummy≠0, then DATA if words≠0, else GAP.
- DATA entry and each word boundary:
  - If wr_valid_i: load tsize=32, din[31:0]=wr_data_i, pulse wr_ready_o, decrement the word counter.
  - Else: go to DWAIT with sh_busy_o=0, cs_no held low. Leave DWAIT the cycle wr_valid_i is seen.
  - After the last word ends, go to GAP.
- MSB_FIRST=1 nibble order: din[3:0] holds the top nibble of the field, din[7:4] the next, and so on. Bits above tsize are 0.
- GAP: sh_busy_o=0, cs_no=1, count CS_GAP_CYC cycles. On the first GAP cycle pulse done_o. Then IDLE.
- abort_i in any non-IDLE/non-GAP state: next edge goes to GAP with done_err_o=1 alongside done_o, sh_busy_o=0, no wr_ready_o. abort_i in IDLE or GAP is ignored.
- A segment-end coincident with abort_i: abort wins and wr_ready_o is not pulsed.
- req_valid_i outside IDLE is ignored; latched fields are stable for the whole transaction.

Decomposition:
- qspi_pkg:
  - state enum qspi_xfer_state_e
  - localparams CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32, DIN_W=40, TSIZE_W=6
  - function nib_rev(data, nbits) for MSB_FIRST ordering
- No sub-module needed. The bench instantiates qspi_xfer_ctrl with the existing shifter to close the feedback loop.

Test Plan:
- Opcode 0x06 only (no addr/dummy/data) -> one 3-cycle segment. Wire nibbles 0x0, 0x6. done_o one cycle after segment end, done_err_o=0. cs_no low for exactly the busy window plus 0, then high ≥2 cycles.
- Opcode 0x02, addr 0x123456, 2 words 0xDEADBEEF, 0xCAFEF00D (wr_valid_i always 1) -> wire nibbles 0,2,1,2,3,4,5,6,D,E,A,D,B,E,E,F,C,A,F,E,F,0,0,D. Two wr_ready_o pulses. sh_busy_o continuous.
- Opcode 0xEB, addr 0x000100, dummy=4 -> DUMMY segment tsize=16, sdo=0 for 5 cycles between ADDR and GAP.
- Data with wr_valid_i low for 3 cycles at second word -> DWAIT: sh_busy_o=0, cs_no=0, resume on valid. Word data intact.
- abort_i asserted mid-ADDR -> next cycle sh_busy_o=0, cs_no=1, done_o=done_err_o=1. Next request accepted after CS_GAP_CYC.
- rst_i during DATA -> next edge all outputs at reset values. A new request completes normally.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared types and helpers for the quad-SPI transaction sequencer.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DWAIT,
    DATA,
    GAP
  } qspi_xfer_state_e;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 32;
  localparam int DIN_W     = 40;
  localparam int TSIZE_W   = 6;

  // The shifter emits din[3:0] first, so the field's top nibble is moved to the bottom.
  function automatic logic [DIN_W-1:0] nib_rev(input logic [DIN_W-1:0] data, input int nbits);
    logic [DIN_W-1:0] res;
    int n;
    res = '0;
    n   = nbits / 4;
    for (int i = 0; i < DIN_W / 4; i++) begin
      if (i < n) res[i*4 +: 4] = data[(n-1-i)*4 +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/qspi_xfer_ctrl.sv
// Quad-SPI transaction sequencer: splits one flash command into back-to-back
// shifter segments and owns chip-select and the completion pulse.
module qspi_xfer_ctrl
  import qspi_pkg::*;
#(
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned CS_GAP_CYC = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [7:0]           req_opcode_i,
  input  logic                 req_addr_en_i,
  input  logic [23:0]          req_addr_i,
  input  logic [3:0]           req_dummy_i,
  input  logic [7:0]           req_words_i,
  input  logic                 wr_valid_i,
  input  logic [31:0]          wr_data_i,
  output logic                 wr_ready_o,
  input  logic                 abort_i,
  output logic                 sh_busy_o,
  output logic [TSIZE_W-1:0]   sh_tsize_o,
  output logic [DIN_W-1:0]     sh_din_o,
  input  logic [TSIZE_W-1:0]   sh_bit_index_i,
  output logic                 cs_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 done_err_o
);

  localparam logic [3:0] GAP_LAST = 4'(CS_GAP_CYC - 1);

  qspi_xfer_state_e   state_q;
  logic               addr_en_q;
  logic [23:0]        addr_q;
  logic [3:0]         dummy_q;
  logic [7:0]         words_q;
  logic [3:0]         gap_cnt_q;

  qspi_xfer_state_e   phase_d;
  logic [TSIZE_W-1:0] tsize_d;
  logic [DIN_W-1:0]   din_d;
  logic               seg_end;
  logic               advance;

  function automatic logic [DIN_W-1:0] order_nib(input logic [DIN_W-1:0] d, input int nbits);
    return MSB_FIRST ? nib_rev(d, nbits) : d;
  endfunction

  // Pick the segment that follows the current one; DWAIT re-evaluates every cycle.
  always_comb begin
    seg_end = sh_busy_o && (sh_bit_index_i == sh_tsize_o);
    advance = (seg_end && (state_q inside {CMD, ADDR, DUMMY, DATA})) || (state_q == DWAIT);
    phase_d = (words_q != 8'd0) ? DATA : GAP;
    case (state_q)
      CMD: begin
        if (addr_en_q)              phase_d = ADDR;
        else if (dummy_q != 4'd0)   phase_d = DUMMY;
      end
      ADDR: begin
        if (dummy_q != 4'd0)        phase_d = DUMMY;
      end
      default: ;
    endcase
    if (phase_d == DATA && !wr_valid_i) phase_d = DWAIT;

    tsize_d = '0;
    din_d   = '0;
    case (phase_d)
      ADDR: begin
        tsize_d = TSIZE_W'(ADDR_BITS);
        din_d   = order_nib({{(DIN_W-ADDR_BITS){1'b0}}, addr_q}, ADDR_BITS);
      end
      DUMMY: tsize_d = {dummy_q, 2'b00};
      DATA: begin
        tsize_d = TSIZE_W'(DATA_BITS);
        din_d   = order_nib({{(DIN_W-DATA_BITS){1'b0}}, wr_data_i}, DATA_BITS);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_en_q   <= 1'b0;
      addr_q      <= '0;
      dummy_q     <= '0;
      words_q     <= '0;
      gap_cnt_q   <= '0;
      req_ready_o <= 1'b1;
      cs_no       <= 1'b1;
      sh_busy_o   <= 1'b0;
      sh_tsize_o  <= '0;
      sh_din_o    <= '0;
      wr_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      done_err_o  <= 1'b0;
    end else begin
      wr_ready_o <= 1'b0;
      done_o     <= 1'b0;
      done_err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_en_q   <= req_addr_en_i;
            addr_q      <= req_addr_i;
            dummy_q     <= req_dummy_i;
            words_q     <= req_words_i;
            state_q     <= CMD;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            cs_no       <= 1'b0;
            sh_busy_o   <= 1'b1;
            sh_tsize_o  <= TSIZE_W'(CMD_BITS);
            sh_din_o    <= order_nib({{(DIN_W-CMD_BITS){1'b0}}, req_opcode_i}, CMD_BITS);
          end
        end
        GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_q     <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          // Abort takes priority over any segment boundary in the same cycle.
          if (abort_i || (advance && phase_d == GAP)) begin
            state_q    <= GAP;
            cs_no      <= 1'b1;
            sh_busy_o  <= 1'b0;
            sh_tsize_o <= '0;
            sh_din_o   <= '0;
            done_o     <= 1'b1;
            done_err_o <= abort_i;
            gap_cnt_q  <= GAP_LAST;
          end else if (advance) begin
            state_q    <= phase_d;
            sh_busy_o  <= (phase_d != DWAIT);
            sh_tsize_o <= tsize_d;
            sh_din_o   <= din_d;
            if (phase_d == DATA) begin
              wr_ready_o <= 1'b1;
              words_q    <= words_q - 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_xfer_ctrl.sv
// Bench for qspi_xfer_ctrl: models the nibble shifter and scores the wire stream.
module tb_qspi_xfer_ctrl;
  import qspi_pkg::*;

  localparam int GAP_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_opcode_i = '0;
  logic        req_addr_en_i = 1'b0;
  logic [23:0] req_addr_i = '0;
  logic [3:0]  req_dummy_i = '0;
  logic [7:0]  req_words_i = '0;
  logic        wr_valid_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic        wr_ready_o;
  logic        abort_i = 1'b0;
  logic        sh_busy_o;
  logic [5:0]  sh_tsize_o;
  logic [39:0] sh_din_o;
  logic [5:0]  bitIdx;
  logic        cs_no;
  logic        busy_o;
  logic        done_o;
  logic        done_err_o;

  typedef struct {
    logic [7:0]  opcode;
    logic        addrEn;
    logic [23:0] addr;
    logic [3:0]  dummy;
    logic [7:0]  words;
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    int          expCsLow;
  } vec_t;

  vec_t vecs[6];

  int nChecks = 0;
  int nFail = 0;
  logic [3:0] expQ[$];
  logic chkNib = 1'b1;

  int csLow, dwaitCyc, gapCyc, wrReadyCnt, doneCnt;
  logic doneErr, donePrevBusy, prevBusy = 1'b0;

  logic [31:0] words[2];
  int wIdx = 0, stallWord = -1, stallCycles = 0, stallLeft = 0;

  qspi_xfer_ctrl #(.MSB_FIRST(1'b1), .CS_GAP_CYC(GAP_CYC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_addr_en_i(req_addr_en_i),
    .req_addr_i(req_addr_i), .req_dummy_i(req_dummy_i), .req_words_i(req_words_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .abort_i(abort_i),
    .sh_busy_o(sh_busy_o), .sh_tsize_o(sh_tsize_o), .sh_din_o(sh_din_o),
    .sh_bit_index_i(bitIdx),
    .cs_no(cs_no), .busy_o(busy_o), .done_o(done_o), .done_err_o(done_err_o)
  );

  always #5 clk = ~clk;

  // Shifter model: index walks 0,4,..,tsize and restarts at the boundary cycle.
  always @(posedge clk) begin
    if (rst_i || !sh_busy_o || bitIdx == sh_tsize_o) bitIdx <= 6'd0;
    else bitIdx <= bitIdx + 6'd4;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    nChecks++;
    nFail++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Wire monitor and per-transaction counters.
  always @(negedge clk) begin
    logic [63:0] din64;
    logic [3:0] nib;
    if (sh_busy_o && bitIdx < sh_tsize_o && chkNib) begin
      din64 = {24'b0, sh_din_o};
      nib = din64[bitIdx +: 4];
      if (expQ.size() == 0) timeoutFail("nibble_unexpected");
      else check("wire_nibble", 64'(nib), 64'(expQ.pop_front()));
    end
    if (!cs_no) csLow++;
    if (!cs_no && !sh_busy_o) dwaitCyc++;
    if (busy_o && cs_no) gapCyc++;
    if (wr_ready_o) wrReadyCnt++;
    if (done_o) begin
      doneCnt++;
      doneErr = done_err_o;
      donePrevBusy = prevBusy;
    end
    prevBusy = sh_busy_o;
  end

  // Write-word feeder with an optional stall before the second word.
  always @(negedge clk) begin
    if (wr_ready_o) begin
      wIdx++;
      wr_data_i = (wIdx < 2) ? words[wIdx] : 32'h0;
      if (stallWord == wIdx) begin
        wr_valid_i = 1'b0;
        stallLeft = stallCycles;
      end
    end else if (!wr_valid_i && stallLeft > 0 && !sh_busy_o && !cs_no) begin
      stallLeft--;
      if (stallLeft == 0) wr_valid_i = 1'b1;
    end
  end

  task automatic pushExpected(input vec_t v);
    logic [31:0] w;
    expQ.push_back(v.opcode[7:4]);
    expQ.push_back(v.opcode[3:0]);
    if (v.addrEn) for (int i = 5; i >= 0; i--) expQ.push_back(v.addr[i*4 +: 4]);
    for (int i = 0; i < int'(v.dummy); i++) expQ.push_back(4'h0);
    for (int k = 0; k < int'(v.words); k++) begin
      w = (k == 0) ? v.w0 : v.w1;
      for (int i = 7; i >= 0; i--) expQ.push_back(w[i*4 +: 4]);
    end
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) timeoutFail(name);
  endtask

  task automatic startReq(input vec_t v);
    waitReady("ready_before_req");
    expQ.delete();
    pushExpected(v);
    csLow = 0; dwaitCyc = 0; gapCyc = 0; wrReadyCnt = 0; doneCnt = 0;
    doneErr = 1'b0; donePrevBusy = 1'b0;
    words[0] = v.w0; words[1] = v.w1; wIdx = 0;
    wr_data_i = v.w0; wr_valid_i = 1'b1;
    stallWord = (v.stall > 0) ? 1 : -1; stallCycles = v.stall; stallLeft = 0;
    req_opcode_i = v.opcode; req_addr_en_i = v.addrEn; req_addr_i = v.addr;
    req_dummy_i = v.dummy; req_words_i = v.words; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_opcode_i = ~v.opcode; req_addr_en_i = ~v.addrEn; req_addr_i = ~v.addr;
    req_dummy_i = ~v.dummy; req_words_i = 8'hFF;
    @(negedge clk);
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int n = 0;
    startReq(v);
    while (doneCnt == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (doneCnt == 0) timeoutFail("done_timeout");
    waitReady("ready_after_done");
  endtask

  task automatic checkOutput(input vec_t v);
    check("done_count", 64'(doneCnt), 64'd1);
    check("done_err", 64'(doneErr), 64'd0);
    check("done_after_seg_end", 64'(donePrevBusy), 64'd1);
    check("cs_low_cycles", 64'(csLow), 64'(v.expCsLow));
    check("dwait_cycles", 64'(dwaitCyc), 64'(v.stall));
    check("wr_ready_pulses", 64'(wrReadyCnt), 64'(v.words));
    check("gap_cycles", 64'(gapCyc), 64'(GAP_CYC));
    check("nibbles_left", 64'(expQ.size()), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    check({tag, "_cs_no"}, 64'(cs_no), 64'd1);
    check({tag, "_sh_busy"}, 64'(sh_busy_o), 64'd0);
    check({tag, "_tsize"}, 64'(sh_tsize_o), 64'd0);
    check({tag, "_din"}, 64'(sh_din_o), 64'd0);
    check({tag, "_wr_ready"}, 64'(wr_ready_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'({done_o, done_err_o}), 64'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{8'h06, 1'b0, 24'h000000, 4'd0,  8'd0, 32'h0,        32'h0,        0, 3};
    vecs[1] = '{8'h02, 1'b1, 24'h123456, 4'd0,  8'd2, 32'hDEADBEEF, 32'hCAFEF00D, 0, 28};
    vecs[2] = '{8'hEB, 1'b1, 24'h000100, 4'd4,  8'd0, 32'h0,        32'h0,        0, 15};
    vecs[3] = '{8'h02, 1'b1, 24'hABCDEF, 4'd0,  8'd2, 32'h12345678, 32'h9ABCDEF0, 3, 31};
    vecs[4] = '{8'h0B, 1'b0, 24'h000000, 4'd15, 8'd1, 32'h0F1E2D3C, 32'h0,        0, 28};
    vecs[5] = '{8'h32, 1'b0, 24'h000000, 4'd0,  8'd1, 32'hA5A55A5A, 32'h0,        0, 12};

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Abort in IDLE is ignored.
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    @(negedge clk);
    check("idle_abort_ready", 64'({req_ready_o, busy_o, cs_no}), 64'b101);

    // Abort in the middle of the address phase.
    chkNib = 1'b0;
    startReq('{8'h03, 1'b1, 24'h0ABCDE, 4'd0, 8'd1, 32'h11112222, 32'h0, 0, 0});
    n = 0;
    while (!(sh_busy_o && sh_tsize_o == 6'd24 && bitIdx == 6'd8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeoutFail("addr_phase_wait");
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_outputs", 64'({sh_busy_o, cs_no, done_o, done_err_o}), 64'b0111);
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_gap_len", 64'(n), 64'(GAP_CYC));
    chkNib = 1'b1;
    applyStimulus(vecs[0]);
    checkOutput(vecs[0]);

    // Abort coinciding with a word boundary: no wr_ready pulse.
    startReq(vecs[1]);
    n = 0;
    while (!(wrReadyCnt == 1 && sh_busy_o && sh_tsize_o == 6'd32 && bitIdx == 6'd32) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeoutFail("word_boundary_wait");
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("seg_abort_wr_ready", 64'(wr_ready_o), 64'd0);
    check("seg_abort_done", 64'({sh_busy_o, cs_no, done_o, done_err_o}), 64'b0111);
    waitReady("ready_after_seg_abort");
    expQ.delete();

    // Synchronous reset during the data phase, then a clean transaction.
    startReq(vecs[1]);
    n = 0;
    while (!(sh_busy_o && sh_tsize_o == 6'd32) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeoutFail("data_phase_wait");
    rst_i = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    rst_i = 1'b0;
    expQ.delete();
    @(negedge clk);
    applyStimulus(vecs[1]);
    checkOutput(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
